spi_controller: RTL
===================

SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: one clock; reset is synchronous and active-high.
REQ-002 Parameter CLK_DIV, default 4, SHALL be the sclk half-period in iclk cycles (legal range >=1).
REQ-003 Parameter GAP_CYCLES, default 16, SHALL be the post-frame idle time in iclk cycles with sclk held low (legal range >=1).
REQ-004 Ports SHALL be as follows:
- iclk     in   1  internal clock; all logic on rising edge
- rst      in   1  synchronous active-high reset
- start    in   1  request a frame; sampled only in IDLE
- rw       in   1  1 = write, 0 = read; latched on accept
- addr     in   7  register address; latched on accept
- wdata    in   8  write data; latched on accept
- poci     in   1  serial data from the peripheral
- sclk     out  1  serial clock to the peripheral
- pico     out  1  serial data to the peripheral
- busy     out  1  high from the cycle after accept until the frame ends
- done     out  1  one-cycle completion pulse
- rdata    out  8  last read byte

Function
REQ-005 The FSM SHALL have three states, IDLE, SHIFT and GAP, with transitions IDLE->SHIFT on start, SHIFT->GAP after the 16th sclk falling edge, and GAP->IDLE after GAP_CYCLES cycles.
REQ-006 On accept (start=1 in IDLE at cycle T), the 16-bit TX register SHALL load {rw, addr[6:0], wdata[7:0]}, and at T+1 the state SHALL be SHIFT with busy=1, sclk=0 and pico=bit15.
REQ-007 Bits SHALL be transmitted MSB first, the command byte first and then the data byte.
REQ-008 A half-period counter SHALL toggle sclk every CLK_DIV iclk cycles in SHIFT, with the first rise at T+1+CLK_DIV.
REQ-009 pico SHALL change only in the cycle sclk falls (shift TX left by one), so that it is stable across every rising edge.
REQ-010 poci SHALL be sampled into a 16-bit RX shift register in the cycle sclk rises.
REQ-011 The 16th falling edge, at T+1+32*CLK_DIV, SHALL move the state to GAP with sclk=0 and pico=0 held for GAP_CYCLES cycles, so that the peripheral's sclk-stop reset fires.
REQ-012 At the end of GAP, the state SHALL become IDLE, busy SHALL be 0, and done SHALL be 1 for exactly that cycle, which is T+1+32*CLK_DIV+GAP_CYCLES.
REQ-013 In the done cycle, for rw=0, rdata SHALL load RX[7:0] (the bits sampled on rises 9-16); for rw=1, rdata SHALL hold its previous value.
REQ-014 start asserted while busy SHALL be ignored, with no queuing and no effect on latched fields.
REQ-015 start asserted in the done cycle SHALL be accepted, because the state is IDLE.
REQ-016 Changes on rw, addr or wdata after accept SHALL have no effect on the frame in progress.
REQ-017 In IDLE, sclk SHALL be 0, pico SHALL be 0, and poci SHALL be ignored.

Reset
REQ-018 rst=1 at any clock edge SHALL force the state to IDLE, with sclk=0, pico=0, busy=0, done=0, rdata=8'h00, and all counters and shift registers cleared.
REQ-019 rst asserted mid-SHIFT or mid-GAP SHALL abort the frame with no done pulse, and rdata SHALL be cleared.
REQ-020 rst SHALL take priority over a simultaneous start, so the start is not accepted.

Verification
REQ-021 Write, defaults: start at T with rw=1, addr=7'h05, wdata=8'hA5 -> pico over 16 rises = 1000_0101_1010_0101; done at T+145 only; busy high T+1..T+144; rdata unchanged.
REQ-022 Read, defaults: rw=0, addr=7'h0A, peripheral model drives 8'h3C on rises 9-16 -> rdata=8'h3C in the done cycle; command bits on pico = 0000_1010.
REQ-023 CLK_DIV=1, GAP_CYCLES=1: sclk period is 2 iclk cycles; done at T+34; exactly 16 rising edges counted.
REQ-024 start pulsed at T+10 during busy with different fields -> ignored; the frame completes with the original fields; back-to-back start in the done cycle -> second frame's busy rises next cycle.
REQ-025 rst asserted at T+50 mid-read -> next cycle sclk=0, busy=0, rdata=0; no done pulse; a new start afterwards completes normally.

Source files
------------

// File: rtl/spi_controller.sv
// spi_controller: SPI master for 16-bit register frames.
//   Each frame shifts out {rw, addr[6:0], wdata[7:0]} MSB first while sampling
//   poci, then holds sclk low for GAP_CYCLES cycles so the peripheral resets.
// Ports:
//   iclk          internal clock, all logic on the rising edge
//   rst           synchronous active-high reset
//   start         frame request, sampled only in IDLE
//   rw            1 = write, 0 = read (latched on accept)
//   addr[6:0]     register address (latched on accept)
//   wdata[7:0]    write data (latched on accept)
//   poci          serial data from the peripheral
//   sclk          serial clock to the peripheral
//   pico          serial data to the peripheral
//   busy          high from the cycle after accept until the frame ends
//   done          one-cycle completion pulse (state is IDLE in that cycle)
//   rdata[7:0]    last read byte
module spi_controller #(
   parameter int unsigned CLK_DIV    = 4,
   parameter int unsigned GAP_CYCLES = 16
) (
   input  logic       iclk,
   input  logic       rst,
   input  logic       start,
   input  logic       rw,
   input  logic [6:0] addr,
   input  logic [7:0] wdata,
   input  logic       poci,
   output logic       sclk,
   output logic       pico,
   output logic       busy,
   output logic       done,
   output logic [7:0] rdata
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t           r_state;
   logic [15:0]      r_tx;
   logic [7:0]       r_rx;        // only the last 8 samples (rises 9-16) are ever used
   logic             r_rw;
   logic             r_sclk;
   logic             r_busy;
   logic             r_done;
   logic [7:0]       r_rdata;
   logic [DIV_W-1:0] r_div_cnt;
   logic [4:0]       r_edge_cnt;  // sclk edges taken so far in the frame (32 per frame)
   logic [GAP_W-1:0] r_gap_cnt;

   logic w_div_hit;
   logic w_gap_hit;

   assign w_div_hit = (r_div_cnt == DIV_LAST);
   assign w_gap_hit = (r_gap_cnt == GAP_LAST);

   // pico is the TX MSB; the register empties to zero after 16 shifts,
   // so pico is naturally 0 in GAP and IDLE.
   assign sclk  = r_sclk;
   assign pico  = r_tx[15];
   assign busy  = r_busy;
   assign done  = r_done;
   assign rdata = r_rdata;

   // Frame sequencer: IDLE -> SHIFT -> GAP -> IDLE
   always_ff @(posedge iclk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_tx       <= 16'h0000;
         r_rx       <= 8'h00;
         r_rw       <= 1'b0;
         r_sclk     <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_rdata    <= 8'h00;
         r_div_cnt  <= '0;
         r_edge_cnt <= 5'd0;
         r_gap_cnt  <= '0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_tx       <= {rw, addr, wdata};
                  r_rw       <= rw;
                  r_rx       <= 8'h00;
                  r_busy     <= 1'b1;
                  r_sclk     <= 1'b0;
                  r_div_cnt  <= '0;
                  r_edge_cnt <= 5'd0;
                  r_state    <= ST_SHIFT;
               end
            end

            ST_SHIFT: begin
               if (w_div_hit) begin
                  r_div_cnt  <= '0;
                  r_sclk     <= ~r_sclk;
                  r_edge_cnt <= r_edge_cnt + 5'd1;
                  if (!r_sclk) begin
                     // rising edge: capture peripheral data
                     r_rx <= {r_rx[6:0], poci};
                  end else begin
                     // falling edge: present next bit; 16th fall ends the shift phase
                     r_tx <= {r_tx[14:0], 1'b0};
                     if (r_edge_cnt == 5'd31) begin
                        r_gap_cnt <= '0;
                        r_state   <= ST_GAP;
                     end
                  end
               end else begin
                  r_div_cnt <= r_div_cnt + DIV_W'(1);
               end
            end

            ST_GAP: begin
               if (w_gap_hit) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= ST_IDLE;
                  if (!r_rw) begin
                     r_rdata <= r_rx;
                  end
               end else begin
                  r_gap_cnt <= r_gap_cnt + GAP_W'(1);
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
